// File: rtl/xix_prefix_sequencer_if.sv
// Bus between the IX/IY prefix sequencer and its neighbours (fetch unit, XIX decoder bank).
// Handshake: fetch_valid qualifies fetch_byte for exactly one cycle and is only consumed while
// CM1=1. There is no ready/backpressure. The decoder strobes are single-cycle pulses sampled in EXEC.
interface xix_prefix_sequencer_if #(
  parameter int XPT_WIDTH = 5
) ();
  logic                 fetch_valid;
  logic [7:0]           fetch_byte;
  logic                 phase_step;
  logic                 PR_Reset_XPT;
  logic                 P2_Set_CM1;
  logic                 P2_Reset_XIX;
  logic                 P2_Reset_XIY;
  logic                 CM1;
  logic                 enable;
  logic                 main_enable;
  logic                 is_Y;
  logic [XPT_WIDTH-1:0] XPT;
  logic [XPT_WIDTH-1:0] notXPT;
  logic [7:0]           Source;
  logic [7:0]           notSource;
  logic                 XPT_Fault;
  logic [1:0]           state;

  modport master (
    output fetch_valid, fetch_byte, phase_step, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XIX, P2_Reset_XIY,
    input  CM1, enable, main_enable, is_Y, XPT, notXPT, Source, notSource, XPT_Fault, state
  );

  modport slave (
    input  fetch_valid, fetch_byte, phase_step, PR_Reset_XPT, P2_Set_CM1, P2_Reset_XIX, P2_Reset_XIY,
    output CM1, enable, main_enable, is_Y, XPT, notXPT, Source, notSource, XPT_Fault, state
  );
endinterface

// File: rtl/xix_prefix_sequencer.sv
// DD/FD prefix sequencer: latches prefixes and opcode, holds XIX/XIY state and runs the XPT
// execution-phase counter that drives the XIX decoder bank.
module xix_prefix_sequencer #(
  parameter int XPT_WIDTH = 5,
  parameter int XPT_MAX   = 31
) (
  input  logic                  clock,
  input  logic                  notReset,
  xix_prefix_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    PREFIX = 2'd1,
    EXEC   = 2'd2
  } state_t;

  localparam logic [XPT_WIDTH-1:0] XPT_LAST = XPT_WIDTH'(XPT_MAX);
  localparam logic [7:0] OP_DD = 8'hDD;
  localparam logic [7:0] OP_FD = 8'hFD;
  localparam logic [7:0] OP_ED = 8'hED;

  state_t               state_q;
  logic                 cm1_q;
  logic                 enable_q;
  logic                 main_enable_q;
  logic                 is_y_q;
  logic                 xix_q;
  logic                 xiy_q;
  logic [XPT_WIDTH-1:0] xpt_q;
  logic [XPT_WIDTH-1:0] not_xpt_q;
  logic [7:0]           source_q;
  logic [7:0]           not_source_q;
  logic                 fault_q;

  logic                 xix_nxt;
  logic                 xiy_nxt;
  logic                 step_fault;
  logic [XPT_WIDTH-1:0] xpt_inc;

  always_comb begin
    xix_nxt    = xix_q & ~bus.P2_Reset_XIX;
    xiy_nxt    = xiy_q & ~bus.P2_Reset_XIY;
    step_fault = bus.phase_step & ~bus.PR_Reset_XPT & (xpt_q == XPT_LAST);
    xpt_inc    = xpt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q       <= FETCH;
      cm1_q         <= 1'b1;
      enable_q      <= 1'b0;
      main_enable_q <= 1'b0;
      is_y_q        <= 1'b0;
      xix_q         <= 1'b0;
      xiy_q         <= 1'b0;
      xpt_q         <= '0;
      not_xpt_q     <= '1;
      source_q      <= 8'h00;
      not_source_q  <= 8'hFF;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        FETCH, PREFIX: begin
          if (bus.fetch_valid) begin
            if (bus.fetch_byte == OP_DD || bus.fetch_byte == OP_FD) begin
              // A repeated prefix simply overwrites the previous one.
              xix_q   <= (bus.fetch_byte == OP_DD);
              xiy_q   <= (bus.fetch_byte == OP_FD);
              is_y_q  <= (bus.fetch_byte == OP_FD);
              state_q <= PREFIX;
            end else begin
              source_q     <= bus.fetch_byte;
              not_source_q <= ~bus.fetch_byte;
              xpt_q        <= '0;
              not_xpt_q    <= '1;
              cm1_q        <= 1'b0;
              state_q      <= EXEC;
              if (state_q == PREFIX && bus.fetch_byte != OP_ED) begin
                enable_q      <= 1'b1;
                main_enable_q <= 1'b0;
              end else begin
                // Unprefixed opcodes, and ED after a prefix, run on the main decoder bank.
                xix_q         <= 1'b0;
                xiy_q         <= 1'b0;
                enable_q      <= 1'b0;
                main_enable_q <= 1'b1;
                if (state_q == FETCH) fault_q <= 1'b0;
              end
            end
          end
        end
        EXEC: begin
          xix_q <= xix_nxt;
          xiy_q <= xiy_nxt;
          if (bus.P2_Set_CM1 || step_fault) begin
            state_q       <= FETCH;
            cm1_q         <= 1'b1;
            enable_q      <= 1'b0;
            main_enable_q <= 1'b0;
            if (step_fault) fault_q <= 1'b1;
            if (bus.P2_Set_CM1) begin
              xpt_q     <= '0;
              not_xpt_q <= '1;
            end
          end else begin
            enable_q      <= xix_nxt | xiy_nxt;
            main_enable_q <= ~(xix_nxt | xiy_nxt);
            if (bus.PR_Reset_XPT) begin
              xpt_q     <= '0;
              not_xpt_q <= '1;
            end else if (bus.phase_step) begin
              xpt_q     <= xpt_inc;
              not_xpt_q <= ~xpt_inc;
            end
          end
        end
        default: begin
          state_q <= FETCH;
          cm1_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.CM1         = cm1_q;
  assign bus.enable      = enable_q;
  assign bus.main_enable = main_enable_q;
  assign bus.is_Y        = is_y_q;
  assign bus.XPT         = xpt_q;
  assign bus.notXPT      = not_xpt_q;
  assign bus.Source      = source_q;
  assign bus.notSource   = not_source_q;
  assign bus.XPT_Fault   = fault_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_xix_prefix_sequencer.sv
// Scenario bench for xix_prefix_sequencer: each test pushes expected output snapshots and
// compares them against what the sequencer shows after each clock.
module tb_xix_prefix_sequencer;
  localparam int W = 33;

  logic clock;
  logic notReset;
  int   tests;
  int   failed;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];

  xix_prefix_sequencer_if #(.XPT_WIDTH(5)) bus ();

  xix_prefix_sequencer #(.XPT_WIDTH(5), .XPT_MAX(31)) dut (
    .clock    (clock),
    .notReset (notReset),
    .bus      (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [W-1:0] ev(input logic cm1, input logic en, input logic men,
                                      input logic isy, input logic [4:0] xpt,
                                      input logic [7:0] src, input logic flt, input logic [1:0] st);
    return {cm1, en, men, isy, xpt, ~xpt, src, ~src, flt, st};
  endfunction

  function automatic logic [W-1:0] snap();
    return {bus.CM1, bus.enable, bus.main_enable, bus.is_Y, bus.XPT, bus.notXPT,
            bus.Source, bus.notSource, bus.XPT_Fault, bus.state};
  endfunction

  task automatic drive(input logic fv, input logic [7:0] fb, input logic ps, input logic pr,
                       input logic scm, input logic rx, input logic ry);
    bus.fetch_valid  = fv;
    bus.fetch_byte   = fb;
    bus.phase_step   = ps;
    bus.PR_Reset_XPT = pr;
    bus.P2_Set_CM1   = scm;
    bus.P2_Reset_XIX = rx;
    bus.P2_Reset_XIY = ry;
    @(posedge clock);
    #1;
    act_q.push_back(snap());
    bus.fetch_valid  = 1'b0;
    bus.phase_step   = 1'b0;
    bus.PR_Reset_XPT = 1'b0;
    bus.P2_Set_CM1   = 1'b0;
    bus.P2_Reset_XIX = 1'b0;
    bus.P2_Reset_XIY = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ctl(input logic ps, input logic pr, input logic scm, input logic rx, input logic ry);
    drive(1'b0, 8'h00, ps, pr, scm, rx, ry);
  endtask

  task automatic test_reset();
    notReset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd0));
    #2 notReset = 1'b1;
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h3E, 1'b0, 2'd2));
    fetch(8'h3E);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 5'(k), 8'h3E, 1'b0, 2'd2));
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    #2 notReset = 1'b0;
    #1 act_q.push_back(snap());
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd0));
    #1 notReset = 1'b1;
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL reset: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_ix_inc();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd1));
    fetch(8'hDD);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h23, 1'b0, 2'd2));
    fetch(8'h23);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 5'(k), 8'h23, 1'b0, 2'd2));
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h23, 1'b0, 2'd2));
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h23, 1'b0, 2'd0));
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL ix_inc: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_last_prefix_wins();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h23, 1'b0, 2'd1));
    fetch(8'hFD);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h23, 1'b0, 2'd1));
    fetch(8'hDD);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h2B, 1'b0, 2'd2));
    fetch(8'h2B);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h2B, 1'b0, 2'd2));
    fetch(8'hDD);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h2B, 1'b0, 2'd0));
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL last_prefix: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_dd_ed();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h2B, 1'b0, 2'd1));
    fetch(8'hDD);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'hED, 1'b0, 2'd2));
    fetch(8'hED);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 8'hED, 1'b0, 2'd2));
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'hED, 1'b0, 2'd0));
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL dd_ed: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_pr_reset();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'hED, 1'b0, 2'd1));
    fetch(8'hFD);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 8'h21, 1'b0, 2'd2));
    fetch(8'h21);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 8'h21, 1'b0, 2'd2));
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 8'h21, 1'b0, 2'd2));
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 8'h21, 1'b0, 2'd2));
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h21, 1'b0, 2'd0));
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL pr_reset: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_fault();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h21, 1'b0, 2'd1));
    fetch(8'hDD);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h34, 1'b0, 2'd2));
    fetch(8'h34);
    for (int k = 1; k <= 31; k++) begin
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 5'(k), 8'h34, 1'b0, 2'd2));
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 8'h34, 1'b1, 2'd0));
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 8'h34, 1'b1, 2'd0));
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 2'd2));
    fetch(8'h00);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 2'd0));
    ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL fault: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       isy;
    logic [7:0] src;
    isy = 1'b0;
    src = 8'h00;
    for (int n = 0; n < 12; n++) begin
      int         r;
      int         nst;
      logic [7:0] op;
      r   = $urandom_range(0, 2);
      nst = $urandom_range(0, 5);
      op  = 8'($urandom_range(0, 127));
      if (r != 0) begin
        isy = (r == 2);
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, isy, 5'd0, src, 1'b0, 2'd1));
        fetch((r == 2) ? 8'hFD : 8'hDD);
      end
      src = op;
      exp_q.push_back(ev(1'b0, r != 0, r == 0, isy, 5'd0, src, 1'b0, 2'd2));
      fetch(op);
      for (int s = 1; s <= nst; s++) begin
        exp_q.push_back(ev(1'b0, r != 0, r == 0, isy, 5'(s), src, 1'b0, 2'd2));
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      exp_q.push_back(ev(1'b1, 1'b0, 1'b0, isy, 5'd0, src, 1'b0, 2'd0));
      ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL back_to_back: got %h expected %h", a, e);
      end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    bus.fetch_valid  = 1'b0;
    bus.fetch_byte   = 8'h00;
    bus.phase_step   = 1'b0;
    bus.PR_Reset_XPT = 1'b0;
    bus.P2_Set_CM1   = 1'b0;
    bus.P2_Reset_XIX = 1'b0;
    bus.P2_Reset_XIY = 1'b0;
    notReset = 1'b0;
    test_reset();
    test_ix_inc();
    test_last_prefix_wins();
    test_dd_ed();
    test_pr_reset();
    test_fault();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
